alien_spawn_ctrl: RTL

//  Frame-driven scheduler for the alien slots. Decides when and into which slot an alien spawns,

---
 rtl/alien_spawn_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/alien_spawn_ctrl.sv
// alien_spawn_ctrl - frame-driven alien slot scheduler.
//
// Decides when, and into which slot, an alien spawns. It sequences each slot
// through IDLE -> ALIVE -> DYING -> IDLE and counts the aliens left in the
// level. When the player dies it freezes play, re-queues live aliens and
// flags level clear once every alien is dead.
//
// Ports:
//   clk               system clock
//   resetN            asynchronous reset, active low
//   startOfFrame      1-clk pulse per video frame; frame timers advance on it
//   level_start       1-clk pulse: reload the level (same effect as reset)
//   player_died       level: player dead / respawning -> freeze play
//   alien_hit         [N_ALIENS] per-slot kill request, any cycle
//   alive             [N_ALIENS] slot is ALIVE
//   dying             [N_ALIENS] slot is DYING (death animation)
//   spawn_pulse       [N_ALIENS] 1-clk pulse: slot just spawned
//   aliens_remaining  [8] aliens not yet killed this level
//   level_clear       all aliens killed; sticky until reset/level_start
//
// Build option: define ALIEN_SPAWN_RR_EN for round-robin slot grant.
// Without it, the lowest-index IDLE slot wins.

// Per-slot state machine. alive/dying are the state bits themselves, so
// both outputs come straight from flops.
module alien_spawn_slot #(
    parameter logic [10:0] DEATH_FRAMES = 11'd30
) (
    input  logic clk,
    input  logic resetN,
    input  logic level_start,
    input  logic freeze_entry,
    input  logic run_go,
    input  logic frame,
    input  logic hit,
    input  logic grant,
    output logic alive,
    output logic dying,
    output logic spawn_pulse
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ALIVE = 2'b01;
    localparam logic [1:0] S_DYING = 2'b10;

    logic [1:0]  state;
    logic [10:0] death_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= S_IDLE;
            death_cnt   <= '0;
            spawn_pulse <= 1'b0;
        end else if (level_start || freeze_entry) begin
            // Freezing drops both ALIVE and DYING slots to IDLE at once.
            state       <= S_IDLE;
            death_cnt   <= '0;
            spawn_pulse <= 1'b0;
        end else if (!run_go) begin
            spawn_pulse <= 1'b0;
        end else begin
            spawn_pulse <= grant;
            case (state)
                S_IDLE:  if (grant) state <= S_ALIVE;
                S_ALIVE: if (hit) begin
                    state     <= S_DYING;
                    death_cnt <= DEATH_FRAMES;
                end
                S_DYING: if (frame) begin
                    // Leave on the frame that takes the count to zero.
                    if (death_cnt <= 11'd1) begin
                        state     <= S_IDLE;
                        death_cnt <= '0;
                    end else begin
                        death_cnt <= death_cnt - 11'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign alive = state[0];
    assign dying = state[1];
endmodule

module alien_spawn_ctrl #(
    parameter int          N_ALIENS     = 2,
    parameter logic [7:0]  TOTAL_ALIENS = 8'd6,
    parameter logic [10:0] FIRST_DELAY  = 11'd60,
    parameter logic [10:0] SPAWN_GAP    = 11'd120,
    parameter logic [10:0] DEATH_FRAMES = 11'd30
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                level_start,
    input  logic                player_died,
    input  logic [N_ALIENS-1:0] alien_hit,
    output logic [N_ALIENS-1:0] alive,
    output logic [N_ALIENS-1:0] dying,
    output logic [N_ALIENS-1:0] spawn_pulse,
    output logic [7:0]          aliens_remaining,
    output logic                level_clear
);
    localparam int PW = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_FREEZE = 1'b1;

    logic [0:0]          gstate;
    logic [10:0]         gap_cnt;
    logic [7:0]          to_spawn;
    logic                run_go, freeze_entry, spawn_ok, found;
    logic [PW-1:0]       grant_idx;
    logic [N_ALIENS-1:0] idle_vec, grant_vec, hit_live;
    logic [3:0]          n_kill, n_requeue;
    logic [8:0]          requeue_sum;
`ifdef ALIEN_SPAWN_RR_EN
    // Next slot to try first; after a grant it moves past the granted slot.
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       cand;
`endif

    function automatic logic [3:0] popcnt(input logic [N_ALIENS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int k = 0; k < N_ALIENS; k++) c = c + {3'b000, v[k]};
        return c;
    endfunction

    always_comb begin
        run_go       = (gstate == ST_RUN) && !player_died && !level_start;
        freeze_entry = (gstate == ST_RUN) &&  player_died && !level_start;
        idle_vec     = ~(alive | dying);
        hit_live     = alien_hit & alive;
        n_kill       = popcnt(hit_live);
        n_requeue    = popcnt(alive);
        requeue_sum  = {1'b0, to_spawn} + {5'b00000, n_requeue};
        found        = 1'b0;
        grant_idx    = '0;
`ifdef ALIEN_SPAWN_RR_EN
        cand = '0;
        for (int k = 0; k < N_ALIENS; k++) begin
            cand = PW'((int'(rr_ptr) + k) % N_ALIENS);
            if (!found && idle_vec[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
`else
        for (int k = 0; k < N_ALIENS; k++) begin
            if (!found && idle_vec[k]) begin
                found     = 1'b1;
                grant_idx = PW'(k);
            end
        end
`endif
        spawn_ok = run_go && startOfFrame && (gap_cnt == 11'd0) &&
                   (to_spawn != 8'd0) && found && !level_clear;
        grant_vec = '0;
        if (spawn_ok) grant_vec[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gstate           <= ST_RUN;
            gap_cnt          <= FIRST_DELAY;
            to_spawn         <= TOTAL_ALIENS;
            aliens_remaining <= TOTAL_ALIENS;
        end else if (level_start) begin
            gstate           <= ST_RUN;
            gap_cnt          <= FIRST_DELAY;
            to_spawn         <= TOTAL_ALIENS;
            aliens_remaining <= TOTAL_ALIENS;
        end else if (gstate == ST_FREEZE) begin
            if (!player_died) begin
                gstate  <= ST_RUN;
                gap_cnt <= FIRST_DELAY;
            end
        end else if (player_died) begin
            // Live aliens go back into the spawn queue; they were not killed.
            gstate <= ST_FREEZE;
            if (requeue_sum > {1'b0, TOTAL_ALIENS}) to_spawn <= TOTAL_ALIENS;
            else                                    to_spawn <= requeue_sum[7:0];
        end else begin
            if ({4'b0000, n_kill} >= aliens_remaining) aliens_remaining <= '0;
            else aliens_remaining <= aliens_remaining - {4'b0000, n_kill};
            if (startOfFrame) begin
                if (gap_cnt != 11'd0) begin
                    gap_cnt <= gap_cnt - 11'd1;
                end else if (spawn_ok) begin
                    gap_cnt  <= SPAWN_GAP;
                    to_spawn <= to_spawn - 8'd1;
                end
            end
        end
    end

`ifdef ALIEN_SPAWN_RR_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)         rr_ptr <= '0;
        else if (level_start) rr_ptr <= '0;
        else if (spawn_ok)   rr_ptr <= (grant_idx == PW'(N_ALIENS - 1)) ? '0 : grant_idx + PW'(1);
    end
`endif

    // Looks at registered state, so clear rises the clk after the last slot idles.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)          level_clear <= 1'b0;
        else if (level_start) level_clear <= 1'b0;
        else if ((aliens_remaining == 8'd0) && !(|(alive | dying))) level_clear <= 1'b1;
    end

    for (genvar i = 0; i < N_ALIENS; i++) begin : g_slot
        alien_spawn_slot #(.DEATH_FRAMES(DEATH_FRAMES)) u_slot (
            .clk          (clk),
            .resetN       (resetN),
            .level_start  (level_start),
            .freeze_entry (freeze_entry),
            .run_go       (run_go),
            .frame        (startOfFrame),
            .hit          (alien_hit[i]),
            .grant        (grant_vec[i]),
            .alive        (alive[i]),
            .dying        (dying[i]),
            .spawn_pulse  (spawn_pulse[i])
        );
    end
endmodule
